idm_arb: RTL
============

// Module: idm_arb
// PURPOSE
//  Single-port access controller for the shared 64x14 instruction/data memory (idm).
//  Arbitrates three requesters: program loader (L), data load/store unit (D) and instruction fetch (F).
//  Drives the memory port itself: mem_adr, mem_we and mem_wd in, mem_rdata back.
//  Sequences every access as IDLE->ACCESS->RESP, registers read data and prevents fetch starvation.
// PARAMETERS
//  ADDR_W      8   address width of all ports
//  DATA_W      14  memory word / read data width
//  WD_W        8   write data width (memory writes the low byte of the word)
//  MEM_DEPTH   64  number of implemented words; addresses >= MEM_DEPTH are out of range
//  STARVE_MAX  3   consecutive lost arbitrations after which F outranks D
// PORTS
//  clk        in   1       clock, all state changes on posedge
//  rst        in   1       asynchronous, active-high reset
//  l_req      in   1       loader write request; hold until l_ack
//  l_adr      in   ADDR_W  loader address
//  l_wd       in   WD_W    loader write data
//  d_req      in   1       data request; hold until d_ack
//  d_we       in   1       1 = store, 0 = load
//  d_adr      in   ADDR_W  data address
//  d_wd       in   WD_W    store data
//  f_req      in   1       fetch (read) request; hold until f_ack
//  f_adr      in   ADDR_W  fetch address (PC)
//  l_ack      out  1       1-cycle completion pulse, loader
//  d_ack      out  1       1-cycle completion pulse, data
//  f_ack      out  1       1-cycle completion pulse, fetch
//  rdata      out  DATA_W  registered read data; valid only while d_ack or f_ack is high
//  err        out  1       pulses with ack when the granted address was out of range
//  busy       out  1       high in ACCESS and RESP
//  grant_id   out  2       0 none, 1 F, 2 D, 3 L (held through ACCESS and RESP)
//  mem_adr    out  ADDR_W  memory address
//  mem_we     out  1       memory write enable
//  mem_wd     out  WD_W    memory write data
//  mem_rdata  in   DATA_W  combinational memory read data
// BEHAVIOUR
//  Reset (async): state=IDLE; rdata, mem_adr, mem_wd = 0; all acks, err, busy, mem_we, grant_id = 0; starve_cnt=0.
//  States:
//  - IDLE: sample requests on posedge.
//    - Winner priority: L > (F if starve_cnt==STARVE_MAX) > D > F.
//    - Latch winner's adr/we/wd (L: we=1; F: we=0); go ACCESS.
//    - No request: stay IDLE, grant_id=0.
//  - ACCESS (1 cycle):
//    - mem_adr = latched adr.
//    - mem_we = latched we AND adr<MEM_DEPTH; it is never high outside ACCESS.
//    - On posedge: rdata <= (in range && !we) ? mem_rdata : 0; go RESP.
//    - Stores leave rdata unchanged.
//  - RESP (1 cycle):
//    - Exactly one ack high, matching grant_id; err high if out of range.
//    - Next state is IDLE unconditionally.
//  Latency: request seen in IDLE -> ack 2 cycles later; max throughput one access per 3 cycles.
//  Handshake:
//    - A requester drops req on the posedge where its ack is seen.
//    - Requests are sampled only in IDLE, so req still high in RESP is ignored.
//    - Port inputs changing while not granted are ignored; granted inputs are already latched.
//  Starvation:
//    - In IDLE, F pending but not granted: starve_cnt += 1, saturating at STARVE_MAX.
//    - F granted: starve_cnt = 0.
//    - L always wins, even over a boosted F.
//  Out-of-range (adr >= MEM_DEPTH): no write, rdata=0, err pulses with ack.
//  Reset mid-access: mem_we drops immediately and no partial write occurs.
//    In-flight access is dropped with no ack; the requester must re-request after reset.
//  Simultaneous L/D/F in the same IDLE cycle: resolved purely by the priority above.
// TESTING
//  1 Reset: rst=1 mid-ACCESS with d_we=1 -> mem_we=0 at once, all outputs 0, mem word unchanged.
//  2 F read: f_req, f_adr=2, mem[2]=14'h2802 -> f_ack 2 cycles later, rdata=14'h2802, grant_id=1.
//  3 D store: d_req, d_we=1, d_adr=32, d_wd=8'hA5 -> mem_we one cycle; mem[32][7:0]=8'hA5; d_ack; err=0.
//  4 Priority: L, D, F all high -> order of acks L, then D, then F (no starvation yet).
//  5 Starvation, STARVE_MAX=3: D and F held high continuously.
//    - Expected grant sequence: D, D, D, F, D, D, D, F...
//  6 Out of range: d_req load d_adr=8'd64 -> d_ack with err=1, rdata=0, mem_we never high.

Source files
------------

// File: rtl/idm_arb.sv
// Single-port access controller for the shared instruction/data memory.
// Arbitrates loader, data and fetch requesters through an IDLE -> ACCESS -> RESP sequence.
module idm_arb #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 14,
  parameter int WD_W       = 8,
  parameter int MEM_DEPTH  = 64,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_adr,
  input  logic [WD_W-1:0]   l_wd,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_adr,
  input  logic [WD_W-1:0]   d_wd,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_adr,
  output logic              l_ack,
  output logic              d_ack,
  output logic              f_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [WD_W-1:0]   mem_wd,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {G_NONE = 2'd0, G_F = 2'd1, G_D = 2'd2, G_L = 2'd3} grant_t;

  localparam int                SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W + 1)'(MEM_DEPTH);

  state_t            state, state_d;
  grant_t            grant, win;
  logic [SW-1:0]     starve_cnt;
  logic              lat_we, lat_oor;
  logic [ADDR_W-1:0] win_adr;
  logic [WD_W-1:0]   win_wd;
  logic              win_we, win_oor;

  // Winner selection and next state; only meaningful while IDLE.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state;
    win     = G_NONE;
    win_adr = '0;
    win_wd  = '0;
    win_we  = 1'b0;
    if (l_req) begin
      win = G_L; win_adr = l_adr; win_wd = l_wd; win_we = 1'b1;
    end else if (f_req && starve_cnt == STARVE_LIM) begin
      win = G_F; win_adr = f_adr;
    end else if (d_req) begin
      win = G_D; win_adr = d_adr; win_wd = d_wd; win_we = d_we;
    end else if (f_req) begin
      win = G_F; win_adr = f_adr;
    end
    win_oor = ({1'b0, win_adr} >= DEPTH_W);
    case (state)
      IDLE:    if (win != G_NONE) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= G_NONE;
      starve_cnt <= '0;
      lat_we     <= 1'b0;
      lat_oor    <= 1'b0;
      mem_adr    <= '0;
      mem_wd     <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          grant <= win;
          if (win != G_NONE) begin
            mem_adr <= win_adr;
            mem_wd  <= win_wd;
            lat_we  <= win_we;
            lat_oor <= win_oor;
          end
          // A pending fetch that loses this arbitration ages toward the boost.
          if (win == G_F)                            starve_cnt <= '0;
          else if (f_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
        end
        ACCESS: if (!lat_we) rdata <= lat_oor ? '0 : mem_rdata;
        RESP:   grant <= G_NONE;
        default: ;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset removes the write enable immediately.
  assign busy     = (state != IDLE);
  assign mem_we   = (state == ACCESS) && lat_we && !lat_oor;
  assign l_ack    = (state == RESP) && (grant == G_L);
  assign d_ack    = (state == RESP) && (grant == G_D);
  assign f_ack    = (state == RESP) && (grant == G_F);
  assign err      = (state == RESP) && lat_oor;
  assign grant_id = grant;

endmodule
